// File: rtl/four_bit_comparator_pkg.sv
// Shared result-bit positions and the gt/eq/lt flag bundle that ripples through the compare cascade.
package four_bit_comparator_pkg;

  localparam int R_GT    = 0;
  localparam int R_EQ    = 1;
  localparam int R_LT    = 2;
  localparam int R_VALID = 3;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_flags_t;

endpackage

// File: rtl/cmp_bit_slice.sv
// One bit of the MSB-first compare cascade. A settled gt/lt from above passes through;
// on an upstream tie this bit decides. INVERT swaps the decision (sign bit of a signed compare).
import four_bit_comparator_pkg::*;

module cmp_bit_slice #(
  parameter bit INVERT = 1'b0
) (
  input  logic       a_i,
  input  logic       b_i,
  input  cmp_flags_t i_flags,
  output cmp_flags_t o_flags
);

  logic w_a_wins;
  logic w_b_wins;

  assign w_a_wins = INVERT ? (~a_i & b_i) : (a_i & ~b_i);
  assign w_b_wins = INVERT ? (a_i & ~b_i) : (~a_i & b_i);

  always_comb begin
    o_flags = i_flags;
    if (i_flags.eq) begin
      o_flags.gt = w_a_wins;
      o_flags.lt = w_b_wins;
      o_flags.eq = (a_i == b_i);
    end
  end

endmodule

// File: rtl/four_bit_comparator.sv
// Registered WIDTH-bit magnitude comparator, R = {VALID, LT, EQ, GT}, one cycle of latency.
// Define FOUR_BIT_COMPARATOR_SIGNED_EN for a two's-complement compare; unsigned otherwise.
import four_bit_comparator_pkg::*;

module four_bit_comparator #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [3:0]       R
);

`ifdef FOUR_BIT_COMPARATOR_SIGNED_EN
  localparam bit SIGNED_CMP = 1'b1;
`else
  localparam bit SIGNED_CMP = 1'b0;
`endif

  // w_chain[WIDTH] is the seed above the MSB; w_chain[0] is the final verdict.
  cmp_flags_t w_chain [WIDTH:0];
  cmp_flags_t r_flags;
  logic       r_valid;

  assign w_chain[WIDTH] = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};

  genvar gi;
  generate
    for (gi = WIDTH - 1; gi >= 0; gi--) begin : g_slice
      cmp_bit_slice #(
        .INVERT (SIGNED_CMP && (gi == WIDTH - 1))
      ) u_slice (
        .a_i     (A[gi]),
        .b_i     (B[gi]),
        .i_flags (w_chain[gi+1]),
        .o_flags (w_chain[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
      r_valid <= 1'b0;
    end else begin
      r_flags <= w_chain[0];
      r_valid <= 1'b1;
    end
  end

  always_comb begin
    R          = 4'b0000;
    R[R_GT]    = r_flags.gt;
    R[R_EQ]    = r_flags.eq;
    R[R_LT]    = r_flags.lt;
    R[R_VALID] = r_valid;
  end

endmodule

// File: tb/tb_four_bit_comparator.sv
// Directed bench for four_bit_comparator: each step pushes its expected R to a queue and
// pops it one cycle later to compare against the registered output.
module tb_four_bit_comparator;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] R;

  int vectors;
  int miscompares;
  logic [3:0] exp_q [$];

  four_bit_comparator #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .R   (R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] R_RST = 4'b0000;
  localparam logic [3:0] R_GT  = 4'b1001;
  localparam logic [3:0] R_EQ  = 4'b1010;
  localparam logic [3:0] R_LT  = 4'b1100;

  task automatic step(input string tag, input logic r, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] exp);
    logic [3:0] want;
    @(negedge clk);
    rst = r;
    A   = a;
    B   = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s scoreboard empty, observed R=%b", tag, R);
    end else begin
      want = exp_q.pop_front();
      assert (R === want) else begin
        miscompares++;
        $error("FAIL %s A=%b B=%b rst=%b observed R=%b expected R=%b", tag, a, b, r, R, want);
      end
    end
    $display("%s: rst=%b A=%b B=%b R=%b", tag, r, a, b, R);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    A   = 4'b0110;
    B   = 4'b0011;

    // Reset hold, then first valid compare
    step("rst0", 1'b1, 4'b0110, 4'b0011, R_RST);
    step("rst1", 1'b1, 4'b1111, 4'b0000, R_RST);
    step("eq_first", 1'b0, 4'b1100, 4'b1100, R_EQ);

`ifndef FOUR_BIT_COMPARATOR_SIGNED_EN
    step("lt_0101_1010", 1'b0, 4'b0101, 4'b1010, R_LT);
    step("gt_1010_0101", 1'b0, 4'b1010, 4'b0101, R_GT);

    step("b2b_gt", 1'b0, 4'b1100, 4'b0011, R_GT);
    step("b2b_lt", 1'b0, 4'b0011, 4'b1100, R_LT);
    step("b2b_lt2", 1'b0, 4'b0111, 4'b1110, R_LT);
    step("b2b_eq", 1'b0, 4'b1000, 4'b1000, R_EQ);

    step("bnd_zero", 1'b0, 4'b0000, 4'b0000, R_EQ);
    step("bnd_max_gt", 1'b0, 4'b1111, 4'b0000, R_GT);
    step("bnd_max_lt", 1'b0, 4'b0000, 4'b1111, R_LT);
    step("rep_gt0", 1'b0, 4'b1100, 4'b1010, R_GT);
    step("rep_gt1", 1'b0, 4'b1100, 4'b1010, R_GT);

    // Mid-stream reset with 0110/1001 on the bus
    step("ms_pre", 1'b0, 4'b0110, 4'b1001, R_LT);
    step("ms_rst", 1'b1, 4'b0110, 4'b1001, R_RST);
    step("ms_post", 1'b0, 4'b0110, 4'b1001, R_LT);

    step("sgnvec_0101_1010", 1'b0, 4'b0101, 4'b1010, R_LT);
    step("sgnvec_0110_1001", 1'b0, 4'b0110, 4'b1001, R_LT);
    step("sgnvec_1000_0111", 1'b0, 4'b1000, 4'b0111, R_GT);
    step("sgnvec_1111_1111", 1'b0, 4'b1111, 4'b1111, R_EQ);
`else
    step("ms_pre", 1'b0, 4'b0110, 4'b1001, R_GT);
    step("ms_rst", 1'b1, 4'b0110, 4'b1001, R_RST);
    step("ms_post", 1'b0, 4'b0110, 4'b1001, R_GT);

    step("sgn_0101_1010", 1'b0, 4'b0101, 4'b1010, R_GT);
    step("sgn_0110_1001", 1'b0, 4'b0110, 4'b1001, R_GT);
    step("sgn_1000_0111", 1'b0, 4'b1000, 4'b0111, R_LT);
    step("sgn_1111_1111", 1'b0, 4'b1111, 4'b1111, R_EQ);
    step("sgn_0000_1111", 1'b0, 4'b0000, 4'b1111, R_GT);
    step("sgn_1111_0000", 1'b0, 4'b1111, 4'b0000, R_LT);
`endif

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain observed %0d left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
